// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: ALU op codes consumed by the execute stage,
// base opcodes, operand-select encodings and the decode FSM state type.
package rv_pkg;

  localparam logic [3:0] ALU_PASS_B   = 4'd0;
  localparam logic [3:0] ALU_B_PLUS4  = 4'd1;
  localparam logic [3:0] ALU_ADD      = 4'd2;
  localparam logic [3:0] ALU_SUB      = 4'd3;
  localparam logic [3:0] ALU_ADD_CLR0 = 4'd4;
  localparam logic [3:0] ALU_SLL      = 4'd5;
  localparam logic [3:0] ALU_SRL      = 4'd6;
  localparam logic [3:0] ALU_SRA      = 4'd7;
  localparam logic [3:0] ALU_SLT      = 4'd8;
  localparam logic [3:0] ALU_SLTU     = 4'd9;
  localparam logic [3:0] ALU_AND      = 4'd10;
  localparam logic [3:0] ALU_OR       = 4'd11;
  localparam logic [3:0] ALU_XOR      = 4'd12;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [1:0] ASEL_RS1  = 2'd0;
  localparam logic [1:0] ASEL_PC   = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;

  localparam logic BSEL_RS2 = 1'b0;
  localparam logic BSEL_IMM = 1'b1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate builder: produces all five sign-extended
// immediate formats in parallel; the decoder picks one by opcode.
module rv_imm_gen (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_b,
  output logic [31:0] o_imm_u,
  output logic [31:0] o_imm_j
);

  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign o_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
  assign o_imm_u = {i_instr[31:12], 12'b0};
  assign o_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

endmodule

// File: rtl/rv_alu_decode.sv
// RV32I decode / ID-EX register: turns a fetched instruction into the
// registered ALU control bundle, with stall/flush and a sticky illegal trap.
module rv_alu_decode
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        in_ready,
  output logic        out_valid,
  output logic [3:0]  alu_op,
  output logic [1:0]  a_sel,
  output logic        b_sel,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jump,
  output logic [2:0]  funct3_q,
  output logic        trap
);

  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3,
                                                  input logic       alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  w_opc_p0;
  logic [2:0]  w_f3_p0;
  logic [6:0]  w_f7_p0;
  logic [4:0]  w_rd_p0;
  logic        w_f7_ok_p0;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_legal_p0;
  logic [3:0]  w_alu_op_p0;
  logic [1:0]  w_a_sel_p0;
  logic        w_b_sel_p0;
  logic [31:0] w_imm_p0;
  logic        w_wb_p0;
  logic        w_ld_p0, w_st_p0, w_br_p0, w_jp_p0;
  logic        w_unused_pc;

  // pc rides alongside the bundle to EX; decode itself never needs it.
  assign w_unused_pc = ^pc;

  assign w_opc_p0   = instr[6:0];
  assign w_f3_p0    = instr[14:12];
  assign w_f7_p0    = instr[31:25];
  assign w_rd_p0    = instr[11:7];
  assign w_f7_ok_p0 = (w_f7_p0 == 7'h00) ||
                      ((w_f7_p0 == 7'h20) && ((w_f3_p0 == 3'd0) || (w_f3_p0 == 3'd5)));

  rv_imm_gen u_imm_gen (
    .i_instr (instr),
    .o_imm_i (w_imm_i),
    .o_imm_s (w_imm_s),
    .o_imm_b (w_imm_b),
    .o_imm_u (w_imm_u),
    .o_imm_j (w_imm_j)
  );

  always_comb begin
    w_legal_p0  = 1'b0;
    w_alu_op_p0 = ALU_PASS_B;
    w_a_sel_p0  = ASEL_RS1;
    w_b_sel_p0  = BSEL_RS2;
    w_imm_p0    = '0;
    w_wb_p0     = 1'b0;
    w_ld_p0     = 1'b0;
    w_st_p0     = 1'b0;
    w_br_p0     = 1'b0;
    w_jp_p0     = 1'b0;
    case (w_opc_p0)
      OPC_LUI: begin
        w_legal_p0 = 1'b1;
        w_a_sel_p0 = ASEL_ZERO;
        w_b_sel_p0 = BSEL_IMM;
        w_imm_p0   = w_imm_u;
        w_wb_p0    = 1'b1;
      end
      OPC_AUIPC: begin
        w_legal_p0  = 1'b1;
        w_alu_op_p0 = ALU_ADD;
        w_a_sel_p0  = ASEL_PC;
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_u;
        w_wb_p0     = 1'b1;
      end
      OPC_JAL: begin
        w_legal_p0  = 1'b1;
        w_alu_op_p0 = ALU_ADD;
        w_a_sel_p0  = ASEL_PC;
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_j;
        w_wb_p0     = 1'b1;
        w_jp_p0     = 1'b1;
      end
      OPC_JALR: begin
        w_legal_p0  = (w_f3_p0 == 3'd0);
        w_alu_op_p0 = ALU_ADD_CLR0;
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_i;
        w_wb_p0     = 1'b1;
        w_jp_p0     = 1'b1;
      end
      OPC_BRANCH: begin
        w_legal_p0  = (w_f3_p0 != 3'd2) && (w_f3_p0 != 3'd3);
        w_alu_op_p0 = ALU_SUB;
        w_imm_p0    = w_imm_b;
        w_br_p0     = 1'b1;
      end
      OPC_LOAD: begin
        w_legal_p0  = (w_f3_p0 != 3'd3) && (w_f3_p0 != 3'd6) && (w_f3_p0 != 3'd7);
        w_alu_op_p0 = ALU_ADD;
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_i;
        w_wb_p0     = 1'b1;
        w_ld_p0     = 1'b1;
      end
      OPC_STORE: begin
        w_legal_p0  = (w_f3_p0 <= 3'd2);
        w_alu_op_p0 = ALU_ADD;
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_s;
        w_st_p0     = 1'b1;
      end
      OPC_OPIMM: begin
        // Only the shift-immediates carry a funct7 field; ADDI never becomes SUB.
        w_legal_p0  = ((w_f3_p0 == 3'd1) || (w_f3_p0 == 3'd5)) ? w_f7_ok_p0 : 1'b1;
        w_alu_op_p0 = alu_from_funct3(w_f3_p0, (w_f3_p0 == 3'd5) && (w_f7_p0 == 7'h20));
        w_b_sel_p0  = BSEL_IMM;
        w_imm_p0    = w_imm_i;
        w_wb_p0     = 1'b1;
      end
      OPC_OP: begin
        w_legal_p0  = w_f7_ok_p0;
        w_alu_op_p0 = alu_from_funct3(w_f3_p0, w_f7_p0 == 7'h20);
        w_wb_p0     = 1'b1;
      end
      OPC_FENCE: begin
        w_legal_p0 = 1'b1;
      end
      default: begin
        w_legal_p0 = 1'b0;
      end
    endcase
  end

  state_t      r_state;
  logic        r_vld_p1;
  logic [3:0]  r_alu_op_p1;
  logic [1:0]  r_a_sel_p1;
  logic        r_b_sel_p1;
  logic [31:0] r_imm_p1;
  logic [4:0]  r_rs1_p1, r_rs2_p1, r_rd_p1;
  logic        r_rd_we_p1, r_ld_p1, r_st_p1, r_br_p1, r_jp_p1;
  logic [2:0]  r_f3_p1;

  // ID -> EX register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_vld_p1    <= 1'b0;
      r_alu_op_p1 <= ALU_PASS_B;
      r_a_sel_p1  <= ASEL_RS1;
      r_b_sel_p1  <= BSEL_RS2;
      r_imm_p1    <= '0;
      r_rs1_p1    <= '0;
      r_rs2_p1    <= '0;
      r_rd_p1     <= '0;
      r_rd_we_p1  <= 1'b0;
      r_ld_p1     <= 1'b0;
      r_st_p1     <= 1'b0;
      r_br_p1     <= 1'b0;
      r_jp_p1     <= 1'b0;
      r_f3_p1     <= '0;
    end else if (flush) begin
      r_state  <= ST_RUN;
      r_vld_p1 <= 1'b0;
    end else if (r_state == ST_TRAP) begin
      r_vld_p1 <= 1'b0;
    end else if (!stall) begin
      if (in_valid && !w_legal_p0) begin
        r_state  <= ST_TRAP;
        r_vld_p1 <= 1'b0;
      end else begin
        r_vld_p1    <= in_valid;
        r_alu_op_p1 <= w_alu_op_p0;
        r_a_sel_p1  <= w_a_sel_p0;
        r_b_sel_p1  <= w_b_sel_p0;
        r_imm_p1    <= w_imm_p0;
        r_rs1_p1    <= instr[19:15];
        r_rs2_p1    <= instr[24:20];
        r_rd_p1     <= w_rd_p0;
        r_rd_we_p1  <= w_wb_p0 && (w_rd_p0 != 5'd0);
        r_ld_p1     <= w_ld_p0;
        r_st_p1     <= w_st_p0;
        r_br_p1     <= w_br_p0;
        r_jp_p1     <= w_jp_p0;
        r_f3_p1     <= w_f3_p0;
      end
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = r_vld_p1;
  assign alu_op    = r_alu_op_p1;
  assign a_sel     = r_a_sel_p1;
  assign b_sel     = r_b_sel_p1;
  assign imm       = r_imm_p1;
  assign rs1       = r_rs1_p1;
  assign rs2       = r_rs2_p1;
  assign rd        = r_rd_p1;
  assign rd_we     = r_rd_we_p1;
  assign is_load   = r_ld_p1;
  assign is_store  = r_st_p1;
  assign is_branch = r_br_p1;
  assign is_jump   = r_jp_p1;
  assign funct3_q  = r_f3_p1;
  assign trap      = (r_state == ST_TRAP);

endmodule

// File: tb/tb_rv_alu_decode.sv
// Scoreboard bench for rv_alu_decode: directed cases plus random instruction
// streams, checked against a behavioural RV32I decode model.
module tb_rv_alu_decode;

  localparam logic [3:0] A_PASS = 4'd0,  A_ADD = 4'd2,  A_SUB = 4'd3,  A_CLR0 = 4'd4;
  localparam logic [3:0] A_SLL  = 4'd5,  A_SRL = 4'd6,  A_SRA = 4'd7,  A_SLT  = 4'd8;
  localparam logic [3:0] A_SLTU = 4'd9,  A_AND = 4'd10, A_OR  = 4'd11, A_XOR  = 4'd12;
  localparam logic [3:0] F3_ALU [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam logic [6:0] OPCS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                       7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, stall, flush;
  logic [31:0] instr, pc;
  logic        in_ready, out_valid, b_sel, rd_we, is_load, is_store, is_branch, is_jump, trap;
  logic [3:0]  alu_op;
  logic [1:0]  a_sel;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3_q;

  rv_alu_decode dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .pc(pc),
    .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
    .alu_op(alu_op), .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .rs1(rs1),
    .rs2(rs2), .rd(rd), .rd_we(rd_we), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jump(is_jump), .funct3_q(funct3_q), .trap(trap)
  );

  typedef struct {
    logic        vld, trap, chk, care_a, care_b, care_imm;
    logic [3:0]  alu;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        we, ld, st, br, jp;
    logic [2:0]  f3;
  } exp_t;

  exp_t q[$];
  exp_t m_last;
  exp_t mon_e;
  logic m_trap = 1'b0;
  int   checks = 0;
  int   failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic [31:0] hi;
    hi = 32'hFFFF_FFFF << bits;
    return (((v >> (bits - 1)) & 1) != 0) ? (v | hi) : (v & ~hi);
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{vld: 1'b0, trap: 1'b0, chk: 1'b1, care_a: 1'b1, care_b: 1'b1, care_imm: 1'b1,
          alu: 4'd0, asel: 2'd0, bsel: 1'b0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          we: 1'b0, ld: 1'b0, st: 1'b0, br: 1'b0, jp: 1'b0, f3: 3'd0};
    return e;
  endfunction

  // Reference decode; e.vld reports whether the instruction is legal.
  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic wb;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    e = zero_exp();
    e.vld = 1'b1;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = f3;
    wb = 1'b0;
    case (opc)
      7'h37: begin e.care_a = 1'b0; e.bsel = 1'b1; e.imm = ins & 32'hFFFF_F000; wb = 1'b1; end
      7'h17: begin e.alu = A_ADD; e.asel = 2'd1; e.bsel = 1'b1; e.imm = ins & 32'hFFFF_F000; wb = 1'b1; end
      7'h6F: begin
        e.alu = A_ADD; e.asel = 2'd1; e.bsel = 1'b1; wb = 1'b1; e.jp = 1'b1;
        e.imm = sext((((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12) |
                     (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1), 21);
      end
      7'h67: begin
        e.vld = (f3 == 3'd0); e.alu = A_CLR0; e.bsel = 1'b1; wb = 1'b1; e.jp = 1'b1;
        e.imm = sext(ins >> 20, 12);
      end
      7'h63: begin
        e.vld = !(f3 inside {3'd2, 3'd3}); e.alu = A_SUB; e.br = 1'b1;
        e.imm = sext((((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11) |
                     (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1), 13);
      end
      7'h03: begin
        e.vld = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.alu = A_ADD; e.bsel = 1'b1;
        e.imm = sext(ins >> 20, 12); wb = 1'b1; e.ld = 1'b1;
      end
      7'h23: begin
        e.vld = (f3 <= 3'd2); e.alu = A_ADD; e.bsel = 1'b1; e.st = 1'b1;
        e.imm = sext(((ins >> 25) << 5) | ((ins >> 7) & 31), 12);
      end
      7'h13: begin
        if (f3 == 3'd1) e.vld = (f7 == 7'h00);
        else if (f3 == 3'd5) e.vld = (f7 == 7'h00) || (f7 == 7'h20);
        e.alu = (f3 == 3'd5 && f7 == 7'h20) ? A_SRA : F3_ALU[f3];
        e.bsel = 1'b1; e.imm = sext(ins >> 20, 12); wb = 1'b1;
      end
      7'h33: begin
        e.vld = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        e.alu = F3_ALU[f3];
        if (f7 == 7'h20 && f3 == 3'd0) e.alu = A_SUB;
        if (f7 == 7'h20 && f3 == 3'd5) e.alu = A_SRA;
        e.care_imm = 1'b0; wb = 1'b1;
      end
      7'h0F: begin e.care_a = 1'b0; e.care_b = 1'b0; e.care_imm = 1'b0; end
      default: e.vld = 1'b0;
    endcase
    e.we = wb && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k <= 10) r[6:0] = OPCS[k];
    if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
      k = $urandom_range(0, 3);
      if (k < 2) r[31:25] = 7'h00;
      else if (k == 2) r[31:25] = 7'h20;
    end
    return r;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] ins,
                      input logic s, input logic f);
    exp_t e;
    reset = r; in_valid = v; instr = ins; pc = $urandom; stall = s; flush = f;
    if (r) begin
      e = zero_exp(); m_trap = 1'b0;
    end else if (f) begin
      e = m_last; e.vld = 1'b0; e.trap = 1'b0; e.chk = 1'b0; m_trap = 1'b0;
    end else if (m_trap) begin
      e = m_last; e.vld = 1'b0; e.trap = 1'b1; e.chk = 1'b0;
    end else if (s) begin
      e = m_last;
    end else if (v) begin
      e = model_decode(ins);
      if (!e.vld) begin
        e.trap = 1'b1; e.chk = 1'b0; m_trap = 1'b1;
      end
    end else begin
      e = m_last; e.vld = 1'b0; e.trap = 1'b0; e.chk = 1'b0;
    end
    m_last = e;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("in_ready", in_ready, !stall);
      cmp("out_valid", out_valid, mon_e.vld);
      cmp("trap", trap, mon_e.trap);
      if (mon_e.chk) begin
        cmp("alu_op", alu_op, mon_e.alu);
        if (mon_e.care_a) cmp("a_sel", a_sel, mon_e.asel);
        if (mon_e.care_b) cmp("b_sel", b_sel, mon_e.bsel);
        if (mon_e.care_imm) cmp("imm", imm, mon_e.imm);
        cmp("rs1", rs1, mon_e.rs1);
        cmp("rs2", rs2, mon_e.rs2);
        cmp("rd", rd, mon_e.rd);
        cmp("rd_we", rd_we, mon_e.we);
        cmp("flags", {is_load, is_store, is_branch, is_jump},
            {mon_e.ld, mon_e.st, mon_e.br, mon_e.jp});
        cmp("funct3_q", funct3_q, mon_e.f3);
      end
    end
  end

  initial begin
    m_last = zero_exp();
    step(1, 0, 32'h0, 0, 0);
    step(1, 0, 32'h0, 0, 0);
    step(0, 1, 32'h402081B3, 0, 0);
    step(0, 1, 32'h008280E7, 0, 0);
    step(0, 1, 32'h00100013, 0, 0);
    step(0, 1, 32'h40315113, 0, 0);
    step(0, 1, 32'h00315113, 0, 0);
    step(0, 1, 32'h00A12023, 0, 0);
    step(0, 1, 32'hFE208EE3, 0, 0);
    step(0, 1, 32'h123453B7, 0, 0);
    step(0, 1, 32'h402081B3, 1, 0);
    step(0, 1, 32'h00315113, 1, 0);
    step(0, 1, 32'h008280E7, 1, 0);
    step(0, 1, 32'h402081B3, 1, 1);
    step(0, 0, 32'h0, 0, 0);
    step(0, 1, 32'h00000073, 0, 0);
    step(0, 1, 32'h402081B3, 0, 0);
    step(0, 1, 32'h00100013, 1, 0);
    step(0, 1, 32'h00315113, 0, 1);
    step(0, 1, 32'h402081B3, 0, 0);
    step(0, 1, 32'h00000073, 0, 1);
    step(0, 1, 32'hFFDFF0EF, 0, 0);
    step(0, 1, 32'h402091B3, 0, 0);
    step(0, 0, 32'h0, 0, 1);
    step(0, 1, 32'h0000100F, 0, 0);
    step(0, 1, 32'h123453B7, 0, 0);
    step(1, 1, 32'h402081B3, 1, 0);
    step(0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) != 0), rand_instr(),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0));
    end
    step(0, 0, 32'h0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    cmp("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_alu_decode.md
# rv_alu_decode

- Decode/ID-EX stage of the RV32I pipeline. It turns a fetched 32-bit instruction into the registered control bundle that drives the execute-stage ALU: 4-bit ALU op, operand selects, immediate, and writeback/memory/branch flags.
- It is the producing end of the ALU op encoding. One-cycle latency, with stall/flush handshake and a sticky trap state for illegal instructions.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instr/pc valid from fetch
- instr  in  32  raw instruction
- pc  in  32  instruction address
- stall  in  1  execute not accepting; hold outputs
- flush  in  1  kill pipeline contents (branch/trap redirect)
- in_ready  out  1  = ~stall (combinational)
- out_valid  out  1  control bundle valid
- alu_op  out  4  ALU operation code
- a_sel  out  2  0 = rs1, 1 = pc, 2 = zero
- b_sel  out  1  0 = rs2, 1 = imm
- imm  out  32  sign-extended immediate
- rs1, rs2, rd  out  5 each  register indices
- rd_we  out  1  register writeback enable
- is_load, is_store, is_branch, is_jump  out  1 each  class flags
- funct3_q  out  3  funct3 passthrough (branch condition, memory size)
- trap  out  1  high while in TRAP state

## Operation
- ALU op codes, decided here and shared with the ALU:
  - 0 PASS_B, 1 B_PLUS4, 2 ADD, 3 SUB, 4 ADD_CLR0
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 AND, 11 OR, 12 XOR
  - 13–15 are never emitted.
- LUI: PASS_B, b = U-imm.
- AUIPC: ADD, a = pc, b = U-imm.
- JAL: ADD, a = pc, b = J-imm, is_jump = 1. The link pc+4 comes from the EX incrementer.
- JALR (funct3 = 0): ADD_CLR0, a = rs1, b = I-imm, is_jump = 1.
- BRANCH (funct3 ∈ {0,1,4,5,6,7}): SUB, a = rs1, b = rs2, rd_we = 0. The condition is resolved from the Z/N/C/V flags plus funct3_q.
- LOAD (funct3 ∈ {0,1,2,4,5}): ADD rs1 + I-imm.
- STORE (funct3 ∈ {0,1,2}): ADD rs1 + S-imm, rd_we = 0.
- OP-IMM / OP, by funct3:
  - 0: ADD, or SUB when OP and funct7 = 0x20
  - 1: SLL
  - 2: SLT
  - 3: SLTU
  - 4: XOR
  - 5: SRL, or SRA when funct7 = 0x20
  - 6: OR
  - 7: AND
- OP requires funct7 ∈ {0x00, 0x20}, and 0x20 only with funct3 0 or 5. Shift-immediates have the same funct7 rule.
- FENCE: out_valid = 1, alu_op PASS_B, rd_we = 0.
- Everything else is illegal: any other opcode, SYSTEM, and any funct3/funct7 violation.
- rd_we is forced to 0 when rd = 0.
- FSM with states RUN and TRAP:
  - RUN → TRAP: an illegal instruction is accepted (in_valid & ~stall & ~flush). That cycle out_valid = 0 and trap = 1.
  - In TRAP, inputs are discarded and out_valid stays 0.
  - TRAP → RUN: on flush.

## Timing
- Reset (synchronous) outputs: out_valid = 0, trap = 0, state = RUN, all bundle fields 0 (alu_op = 0 PASS_B, imm = 0, rd_we = 0).
- Latency: an instruction accepted at edge N appears on the outputs after edge N.
- Priority: reset > flush > stall > load.
  - flush: out_valid ← 0 next cycle even when stall is high; leaves TRAP.
  - stall without flush: all outputs hold their values.
  - in_valid = 0 and no stall: out_valid ← 0; other fields don't-care.
- Illegal instruction arriving together with flush: discarded, no trap.
- Reset mid-stall: outputs clear on the next edge.

## Structure
- Package rv_pkg holds:
  - ALU op localparams (ALU_PASS_B … ALU_XOR)
  - opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE)
  - a_sel / b_sel encodings
  - FSM state encoding
- One combinational sub-module, rv_imm_gen, builds the I/S/B/U/J immediates. The decode table and pipeline register stay in the top.

## Test plan
- sub x3,x1,x2 (0x402081B3), in_valid = 1 → next cycle: out_valid = 1, alu_op = 3, a_sel = 0, b_sel = 0, rd = 3, rd_we = 1.
- jalr x1,8(x5) (0x008280E7) → alu_op = 4, imm = 8, is_jump = 1, rd_we = 1. Then addi x0,x0,1 (0x00100013) → alu_op = 2, rd_we = 0.
- Shift-immediates: srai x2,x2,3 (0x40315113) → alu_op = 7, imm[4:0] = 3. srli (0x00315113) → alu_op = 6.
- Hold/flush: stall held 3 cycles with a new instr on the inputs → outputs unchanged. stall = 1 together with flush = 1 → out_valid = 0 next cycle.
- Trap: ecall (0x00000073) → trap = 1, out_valid = 0. Then valid instructions → still trapped. Then flush → RUN, and the next legal instruction decodes.
- lui x7,0x12345 (0x123453B7) → alu_op = 0, b_sel = 1, imm = 0x12345000. Assert reset → all outputs 0 the next cycle.
